// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, holding the core in reset until complete.
// mem_we fires one cycle after each 4th byte (s_ready low that cycle); done/core_rst_n rise one cycle after the last write.
module instr_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        BYTE,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [31:0]   word_buf_q, word_buf_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          hs;
    logic [15:0]   full_len;
    logic [31:0]   word_nxt;

    assign hs       = s_valid && s_ready;
    assign full_len = {s_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        word_buf_d  = word_buf_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_nxt    = word_buf_q;
        word_nxt[{byte_cnt_q, 3'b000} +: 8] = s_data;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_LO;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                end
            end
            LEN_LO: begin
                if (hs) begin
                    len_d   = {8'h00, s_data};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (hs) begin
                    len_d = full_len;
                    if (full_len == 16'd0) begin
                        state_d = DONE;
                    end else if (17'(full_len) > DEPTH_W) begin
                        state_d = ERR;
                    end else begin
                        state_d = BYTE;
                    end
                end
            end
            BYTE: begin
                if (hs) begin
                    word_buf_d = word_nxt;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // The last byte goes straight into the output word so WRITE needs no extra cycle.
                    if (byte_cnt_q == 2'd3) begin
                        mem_wdata_d = word_nxt;
                        mem_addr_d  = AW'({word_cnt_q, 2'b00});
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + 16'd1;
                state_d    = (word_cnt_q + 16'd1 == len_q) ? DONE : BYTE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            word_buf_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            word_buf_q  <= word_buf_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Control outputs are pure state decodes, so they follow the state register with no extra delay.
    assign s_ready    = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == BYTE);
    assign busy       = s_ready || (state_q == WRITE);
    assign mem_we     = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);
    assign core_rst_n = (state_q == DONE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for instr_loader: expected writes are queued by the stimulus, popped by a write monitor.
module tb_instr_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;

    instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .areset     (areset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog_q[$];
    logic [31:0] model_mem[DEPTH];
    bit          model_vld[DEPTH];
    logic [31:0] seen_mem[DEPTH];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_writes = 0;
    wr_t         mon_e;
    int          mon_idx;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Write monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (areset && mem_we) begin
            n_writes++;
            chk("we_s_ready_low", 32'(s_ready), 32'd0);
            chk("we_addr_bound", 32'(mem_addr <= 32'((DEPTH - 1) * 4)), 32'd1);
            chk("we_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("we_addr", mem_addr, mon_e.addr);
                chk("we_data", mem_wdata, mon_e.data);
            end
            mon_idx = int'(mem_addr >> 2);
            if (mon_idx < DEPTH) seen_mem[mon_idx] = mem_wdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax, input bit with_start, output int waited);
        bit rdy;
        waited = 0;
        if (gapmax > 0) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            repeat ($urandom_range(0, gapmax)) begin
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        start   = with_start;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk); #1;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                chk("handshake_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    // Reference: word i of the program lands at byte address 4*i, bytes sent LSB first after a 16-bit count.
    task automatic run_load(input int gapmax, input bit inj_start);
        logic [15:0] lenv;
        int          w0;
        int          wt;
        lenv = 16'(prog_q.size());
        w0   = n_writes;
        for (int i = 0; i < prog_q.size(); i++) begin
            exp_q.push_back(wr_t'{addr: 32'(i * 4), data: prog_q[i]});
            model_mem[i] = prog_q[i];
            model_vld[i] = 1'b1;
        end
        do_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("core_held_after_start", 32'(core_rst_n), 32'd0);
        send_byte(lenv[7:0], gapmax, 1'b0, wt);
        send_byte(lenv[15:8], gapmax, 1'b0, wt);
        for (int i = 0; i < prog_q.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(prog_q[i][8*b +: 8], gapmax, inj_start && i == 0 && b == 1, wt);
                if (gapmax == 0 && b == 0 && i > 0) chk("stall_one_cycle_in_write", 32'(wt), 32'd1);
            end
        end
        if (lenv != 16'd0) begin
            @(posedge clk); #1;
        end
        chk("done_after_load", 32'(done), 32'd1);
        chk("core_released", 32'(core_rst_n), 32'd1);
        chk("no_err_after_load", 32'(err), 32'd0);
        chk("not_busy_after_load", 32'(busy), 32'd0);
        chk("write_count", 32'(n_writes - w0), 32'(lenv));
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_err(input logic [15:0] lenv);
        int w0;
        int wt;
        w0 = n_writes;
        do_start();
        send_byte(lenv[7:0], 0, 1'b0, wt);
        send_byte(lenv[15:8], 0, 1'b0, wt);
        chk("err_set", 32'(err), 32'd1);
        chk("err_core_held", 32'(core_rst_n), 32'd0);
        chk("err_not_done", 32'(done), 32'd0);
        chk("err_not_busy", 32'(busy), 32'd0);
        s_valid = 1'b1;
        repeat (6) begin
            s_data = 8'($urandom);
            @(posedge clk); #1;
            chk("err_s_ready_low", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        chk("err_held", 32'(err), 32'd1);
        chk("err_no_writes", 32'(n_writes - w0), 32'd0);
    endtask

    task automatic rand_prog(input int len);
        prog_q.delete();
        for (int i = 0; i < len; i++) prog_q.push_back(32'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int wt;
        int w0;
        for (int i = 0; i < DEPTH; i++) begin
            model_vld[i] = 1'b0;
            model_mem[i] = '0;
            seen_mem[i]  = '0;
        end

        #1;
        check_reset_outputs("rst0");
        @(posedge clk); #1;
        check_reset_outputs("rst1");
        areset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_s_ready", 32'(s_ready), 32'd0);
        chk("idle_core_rst_n", 32'(core_rst_n), 32'd0);

        prog_q = '{32'h0000_0013, 32'h0010_0093};
        run_load(0, 1'b0);

        prog_q.delete();
        run_load(0, 1'b0);

        run_err(16'd65);
        rand_prog(5);
        run_load(0, 1'b0);
        run_err(16'($urandom_range(DEPTH + 1, 65535)));

        for (int k = 0; k < 4; k++) begin
            rand_prog(int'($urandom_range(1, 10)));
            run_load(0, k == 1);
            run_load(3, 1'b0);
        end

        rand_prog(DEPTH);
        run_load(1, 1'b0);

        // Reset while the second word is half received: only the first word may be written.
        rand_prog(3);
        exp_q.push_back(wr_t'{addr: 32'd0, data: prog_q[0]});
        model_mem[0] = prog_q[0];
        w0 = n_writes;
        do_start();
        send_byte(8'd3, 0, 1'b0, wt);
        send_byte(8'd0, 0, 1'b0, wt);
        for (int b = 0; b < 4; b++) send_byte(prog_q[0][8*b +: 8], 0, 1'b0, wt);
        for (int b = 0; b < 2; b++) send_byte(prog_q[1][8*b +: 8], 0, 1'b0, wt);
        areset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst_writes", 32'(n_writes - w0), 32'd1);
        areset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_stays_idle", 32'(busy), 32'd0);
        chk("midrst_exp_drained", 32'(exp_q.size()), 32'd0);
        rand_prog(3);
        run_load(2, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            if (model_vld[i]) chk($sformatf("mem[%0d]", i), seen_mem[i], model_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction-memory capacity in 32-bit words.
REQ-002 Parameter AW, default 32, width of mem_addr (byte address).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 areset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a program load.
REQ-006 s_valid  input  1  byte-stream valid.
REQ-007 s_data  input  8  byte-stream data.
REQ-008 s_ready  output  1  loader accepts s_data when s_valid&&s_ready.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  AW  byte address of write, word aligned (word_index*4).
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 core_rst_n  output  1  active-low reset to the RISCV core; low while not loaded.
REQ-013 busy  output  1  high in LEN_LO, LEN_HI, BYTE, WRITE.
REQ-014 done  output  1  high in DONE.
REQ-015 err  output  1  high in ERR.

Function
REQ-016 FSM states: IDLE, LEN_LO, LEN_HI, BYTE, WRITE, DONE, ERR; all outputs registered or decoded from state only.
REQ-017 Stream format: 16-bit word count len (low byte first), then len words, each 4 bytes little-endian (first byte -> bits 7:0).
REQ-018 IDLE: s_ready=0; start -> LEN_LO, byte_cnt=0, word_cnt=0.
REQ-019 LEN_LO: s_ready=1; on handshake len[7:0]=s_data -> LEN_HI.
REQ-020 LEN_HI: s_ready=1; on handshake len[15:8]=s_data; full len==0 -> DONE; len>DEPTH -> ERR; else BYTE.
REQ-021 BYTE: s_ready=1; each handshake writes s_data to byte lane byte_cnt, byte_cnt increments mod 4; handshake with byte_cnt==3 -> WRITE.
REQ-022 WRITE: exactly one cycle, s_ready=0, mem_we=1, mem_addr=word_cnt*4, mem_wdata=assembled word; word_cnt+1==len -> DONE, else BYTE with word_cnt+1.
REQ-023 Latency: mem_we asserts the cycle after the 4th byte handshake; done and core_rst_n=1 assert the cycle after the final WRITE.
REQ-024 Cycles with s_valid=0 cause no state change; bytes are never dropped or duplicated.
REQ-025 DONE: core_rst_n=1, s_ready=0; start -> LEN_LO with core_rst_n=0 from that next cycle (reload).
REQ-026 ERR: core_rst_n=0, s_ready=0, no writes; start -> LEN_LO; otherwise held until reset.
REQ-027 start while busy is ignored; mem_we is never asserted outside WRITE.
REQ-028 mem_addr never exceeds (DEPTH-1)*4.

Reset
REQ-029 areset low forces, asynchronously: state IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, counters 0.
REQ-030 Reset mid-load discards any partial word; already-written words are not cleared.

Verification
REQ-031 Assert areset low -> all outputs 0, core_rst_n=0, state IDLE within the reset cycle.
REQ-032 start; bytes 02 00 13 00 00 00 93 00 10 00 -> mem_we at addr 0 data 0x00000013, then addr 4 data 0x00100093; done=1, core_rst_n=1 next cycle.
REQ-033 start; bytes 00 00 -> DONE, zero writes, core_rst_n=1.
REQ-034 DEPTH=64; start; bytes 41 00 -> err=1, zero writes, core_rst_n=0; then start + valid stream loads normally.
REQ-035 Random s_valid gaps and a byte held during WRITE -> byte accepted the cycle after WRITE; written words identical to gap-free run.
REQ-036 areset low after 2 bytes of word 1 -> immediate IDLE, no further mem_we; full reload then yields correct memory and done=1.
